// File: rtl/alu_decode_stage.sv
// -----------------------------------------------------------------------------
// alu_decode_stage
//
// Decode-to-execute pipeline stage in front of the ALU. Takes one RV32I
// instruction per valid/ready handshake, decodes it into the ALU operation,
// operand selects and sign-extended immediate, and holds the result in a
// single output register until the execute stage takes it.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous, active-high reset
//   in_valid         instruction present on in_instr
//   in_ready         stage can accept an instruction this cycle
//   in_instr         raw 32-bit instruction word
//   flush            discard the held and the incoming instruction
//   out_valid        decoded fields valid
//   out_ready        execute stage accepts the decoded fields
//   alu_control      ALU op (0000 add ... 1010 sgeu)
//   shift_right_type 1 = logical, 0 = arithmetic (only meaningful for op 1000)
//   src_a_sel        00 rs1, 01 PC, 10 zero
//   src_b_imm        1 = operand B from imm, 0 = rs2
//   imm              sign-extended immediate
//   illegal          instruction could not be decoded
// -----------------------------------------------------------------------------
module alu_decode_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            alu_control,
    output logic                  shift_right_type,
    output logic [1:0]            src_a_sel,
    output logic                  src_b_imm,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  illegal
);

    // ALU operation encodings seen by the execute stage.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SR   = 4'b1000,
        ALU_SGE  = 4'b1001,
        ALU_SGEU = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'b00,
        SRC_A_PC   = 2'b01,
        SRC_A_ZERO = 2'b10
    } src_a_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // -------------------------------------------------------------------------
    // Instruction fields and immediate formats (all sign-extended from bit 31)
    // -------------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_shamt;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    assign imm_i     = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b     = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u     = {in_instr[31:12], 12'b0};
    assign imm_j     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
    // Shift-immediate forms carry only the 5-bit shamt, zero-extended.
    assign imm_shamt = {27'b0, in_instr[24:20]};

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    alu_op_e     dec_alu;
    logic        dec_srt;
    src_a_e      dec_asel;
    logic        dec_bimm;
    logic [31:0] dec_imm;
    logic        dec_ill;

    always_comb begin
        // NOTE: every output of this block gets a default up front so no path
        // through the case statements leaves one unassigned (no latches).
        dec_alu  = ALU_ADD;
        dec_srt  = 1'b1;
        dec_asel = SRC_A_RS1;
        dec_bimm = 1'b0;
        dec_imm  = 32'b0;
        dec_ill  = 1'b0;

        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000: dec_alu = ALU_ADD;
                        3'b001: dec_alu = ALU_SLL;
                        3'b010: dec_alu = ALU_SLT;
                        3'b011: dec_alu = ALU_SLTU;
                        3'b100: dec_alu = ALU_XOR;
                        3'b101: dec_alu = ALU_SR;
                        3'b110: dec_alu = ALU_OR;
                        default: dec_alu = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_alu = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_alu = ALU_SR;
                    dec_srt = 1'b0;
                end else begin
                    dec_ill = 1'b1;
                end
            end

            OPC_OP_IMM: begin
                dec_bimm = 1'b1;
                dec_imm  = imm_i;
                case (funct3)
                    3'b000: dec_alu = ALU_ADD;
                    3'b010: dec_alu = ALU_SLT;
                    3'b011: dec_alu = ALU_SLTU;
                    3'b100: dec_alu = ALU_XOR;
                    3'b110: dec_alu = ALU_OR;
                    3'b111: dec_alu = ALU_AND;
                    3'b001: begin
                        dec_alu = ALU_SLL;
                        dec_imm = imm_shamt;
                        if (funct7 != F7_BASE) dec_ill = 1'b1;
                    end
                    default: begin // 3'b101: srli / srai
                        dec_alu = ALU_SR;
                        dec_imm = imm_shamt;
                        if (funct7 == F7_ALT) begin
                            dec_srt = 1'b0;
                        end else if (funct7 != F7_BASE) begin
                            dec_ill = 1'b1;
                        end
                    end
                endcase
            end

            OPC_LOAD, OPC_JALR: begin
                dec_bimm = 1'b1;
                dec_imm  = imm_i;
            end

            OPC_STORE: begin
                dec_bimm = 1'b1;
                dec_imm  = imm_s;
            end

            OPC_BRANCH: begin
                // The branch target offset rides along for the PC adder; the
                // ALU itself only compares rs1 against rs2.
                dec_imm = imm_b;
                case (funct3)
                    3'b000, 3'b001: dec_alu = ALU_SUB;
                    3'b100:         dec_alu = ALU_SLT;
                    3'b101:         dec_alu = ALU_SGE;
                    3'b110:         dec_alu = ALU_SLTU;
                    3'b111:         dec_alu = ALU_SGEU;
                    default:        dec_ill = 1'b1;
                endcase
            end

            OPC_LUI: begin
                dec_asel = SRC_A_ZERO;
                dec_bimm = 1'b1;
                dec_imm  = imm_u;
            end

            OPC_AUIPC: begin
                dec_asel = SRC_A_PC;
                dec_bimm = 1'b1;
                dec_imm  = imm_u;
            end

            OPC_JAL: begin
                dec_asel = SRC_A_PC;
                dec_bimm = 1'b1;
                dec_imm  = imm_j;
            end

            default: dec_ill = 1'b1;
        endcase

        // Illegal instructions go downstream with neutral fields so the
        // consumer sees nothing but the illegal flag.
        if (dec_ill) begin
            dec_alu  = ALU_ADD;
            dec_srt  = 1'b1;
            dec_asel = SRC_A_RS1;
            dec_bimm = 1'b0;
            dec_imm  = 32'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Handshake and output register
    // -------------------------------------------------------------------------
    logic load;

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            out_valid        <= 1'b0;
            alu_control      <= ALU_ADD;
            shift_right_type <= 1'b1;
            src_a_sel        <= SRC_A_RS1;
            src_b_imm        <= 1'b0;
            imm              <= '0;
            illegal          <= 1'b0;
        end else if (flush) begin
            // Data registers keep stale contents; only the valid bit matters.
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid        <= 1'b1;
            alu_control      <= dec_alu;
            shift_right_type <= dec_srt;
            src_a_sel        <= dec_asel;
            src_b_imm        <= dec_bimm;
            imm              <= DATA_WIDTH'(dec_imm);
            illegal          <= dec_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Decode-to-execute pipeline stage that feeds the ALU.
- Accepts one 32-bit RV32I instruction per valid/ready handshake and decodes opcode/funct3/funct7 into the ALU's 4-bit operation code, shift-right type, operand selects and sign-extended immediate.
- Holds the result in a single output register until the execute stage accepts it.
- Supports backpressure and a pipeline flush.

Parameters:
- DATA_WIDTH, 32, width of immediate output; must be 32 for RV32I.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  instruction present on in_instr
- in_ready  output  1  stage can accept an instruction this cycle
- in_instr  input  32  raw instruction word
- flush  input  1  discard held and incoming instruction
- out_valid  output  1  decoded fields valid
- out_ready  input  1  execute stage accepts the decoded fields
- alu_control  output  4  ALU op: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 shift right, 1001 sge, 1010 sgeu
- shift_right_type  output  1  1 = logical (>>), 0 = arithmetic (>>>); meaningful only for op 1000
- src_a_sel  output  2  00 rs1, 01 PC, 10 zero
- src_b_imm  output  1  1 = SRCB from imm, 0 = rs2
- imm  output  DATA_WIDTH  sign-extended immediate
- illegal  output  1  instruction not decodable

Behaviour:
- Reset (sync, rst=1 at edge) values:
  - out_valid=0
  - alu_control=0000, shift_right_type=1, src_a_sel=00, src_b_imm=0, imm=0, illegal=0
  - rst overrides all other inputs, including mid-transfer; any held instruction is lost.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Load occurs when in_valid && in_ready && !flush.
  - Latency is 1 cycle: fields are registered and appear with out_valid=1 the cycle after acceptance.
  - Registered fields are stable while out_valid && !out_ready.
  - Simultaneous accept and output consumption in one cycle gives full throughput with no bubble.
  - If out_ready=1 and no load occurs, out_valid goes to 0.
- Flush:
  - Flush at the edge sets out_valid=0 and drops any in_instr offered in that cycle.
  - Flush has priority over load and stall; data registers may retain stale values.
- R-type (0110011), selects rs1/rs2:
  - funct7=0000000: funct3 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl (1000, type 1), 110 or, 111 and.
  - funct7=0100000: funct3 000 sub, 101 sra (1000, type 0).
  - Any other funct7/funct3 combination is illegal.
- I-ALU (0010011), rs1/imm, same mapping with no sub:
  - For 001/101, instr[31:25] must be 0000000 (0100000 allowed only for 101 → sra), else illegal.
  - For shifts, imm = {27'b0, instr[24:20]}.
- LOAD (0000011) and JALR (1100111): add, rs1 + I-imm.
- STORE (0100011): add, rs1 + S-imm.
- BRANCH (1100011), rs1/rs2, imm = B-imm (not used by ALU):
  - beq/bne → 0001, blt → 0101, bge → 1001, bltu → 0110, bgeu → 1010.
  - funct3 010/011 is illegal.
- LUI (0110111): add, src_a_sel=10, U-imm.
- AUIPC (0010111): add, src_a_sel=01, U-imm.
- JAL (1101111): add, src_a_sel=01, J-imm.
- Immediate formats, all sign-extended from instr[31]:
  - I = instr[31:20]
  - S = {instr[31:25], instr[11:7]}
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U = {instr[31:12], 12'b0}
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- Illegal instruction (unknown opcode or invalid funct combination):
  - illegal=1, alu_control=0000, src_a_sel=00, src_b_imm=0, imm=0, shift_right_type=1.
  - Still transferred with out_valid=1 so the consumer raises the exception.
- shift_right_type=1 for every op other than sra/srai.

Test Plan:
- Reset, then in_valid=1 with 0x403100B3 (sub x1,x2,x3) → next cycle out_valid=1, alu_control=0001, src_b_imm=0, illegal=0; 0x003100B3 → 0000.
- 0x40335293 (srai x5,x6,3) → alu_control=1000, shift_right_type=0, src_b_imm=1, imm=0x00000003; 0x00335293 (srli) → shift_right_type=1.
- 0xFFF00093 (addi x1,x0,-1) → 0000, imm=0xFFFFFFFF; 0x123450B7 (lui) → src_a_sel=10, imm=0x12345000.
- Backpressure: out_ready=0 for 3 cycles with a second instruction offered → in_ready=0, outputs unchanged; out_ready=1 → second instruction appears next cycle, no loss or duplication; back-to-back stream with out_ready=1 → one result per cycle.
- flush=1 while out_valid=1 and in_valid=1 → next cycle out_valid=0, offered instruction dropped; rst asserted mid-stall → out_valid=0, alu_control=0000.
- Illegal instructions 0xFE3100B3 (bad funct7) and 0x0000007F (bad opcode) → illegal=1, alu_control=0000, out_valid=1; branch 0x00208463 (beq) → 0001, B-imm=0x00000008.
